// File: rtl/cpu_step_controller.sv
// -----------------------------------------------------------------------------
// cpu_step_controller
//
// Run/step/halt sequencer for the pipelined RISC-V core. The core runs on the
// board clock and is advanced by a single registered clock-enable pulse
// (cpu_ce) rather than by a divided clock. After board reset the core is held
// in reset for RST_HOLD cycles. It then free-runs (one cpu_ce every RUN_DIV
// cycles) or single-steps on debounced step-button presses. It stops for good
// once the core reports a halt on an enabled cycle.
//
// Ports:
//   clk_100MHz  in   board clock, the only clock in this block
//   rst_n       in   asynchronous active-low reset
//   btn_step    in   raw step pushbutton (asynchronous, bouncy)
//   sw_run      in   raw run switch (asynchronous), 1 = free-run
//   halt_req    in   halt request from the core, honoured only while cpu_ce=1
//   cpu_rst_n   out  registered active-low reset to the core
//   cpu_ce      out  registered one-cycle core clock-enable
//   halted      out  registered, high in HALTED
//   running     out  registered, high in RUN
//   cycle_count out  number of cpu_ce pulses since reset (wraps)
// -----------------------------------------------------------------------------
module cpu_step_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RUN_DIV         = 2,
    parameter int RST_HOLD        = 16
) (
    input  logic        clk_100MHz,
    input  logic        rst_n,
    input  logic        btn_step,
    input  logic        sw_run,
    input  logic        halt_req,
    output logic        cpu_rst_n,
    output logic        cpu_ce,
    output logic        halted,
    output logic        running,
    output logic [31:0] cycle_count
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int PH_W   = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(RUN_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_PAUSE      = 2'd1,
        ST_RUN        = 2'd2,
        ST_HALTED     = 2'd3
    } state_e;

    // Synchronizers and debouncers
    logic            step_meta_q, step_meta_d;
    logic            step_sync_q, step_sync_d;
    logic            run_meta_q,  run_meta_d;
    logic            run_sync_q,  run_sync_d;
    logic            step_db_q,   step_db_d;
    logic [DB_W-1:0] step_cnt_q,  step_cnt_d;
    logic            run_db_q,    run_db_d;
    logic [DB_W-1:0] run_cnt_q,   run_cnt_d;
    logic            step_prev_q, step_prev_d;
    logic            step_pulse_q, step_pulse_d;

    // Sequencer
    state_e            state_q,       state_d;
    logic [HOLD_W-1:0] hold_cnt_q,    hold_cnt_d;
    logic [PH_W-1:0]   phase_q,       phase_d;
    logic              cpu_rst_n_q,   cpu_rst_n_d;
    logic              cpu_ce_q,      cpu_ce_d;
    logic              halted_q,      halted_d;
    logic              running_q,     running_d;
    logic [31:0]       cycle_count_q, cycle_count_d;
    logic              halt_hit;

    // Returns {new_level, new_count}. The count only advances while the
    // sample disagrees with the accepted level, so any agreeing sample
    // (a glitch ending) restarts the qualification window.
    function automatic logic [DB_W:0] debounce_next(
        input logic            sample,
        input logic            level,
        input logic [DB_W-1:0] cnt
    );
        logic [DB_W-1:0] inc;
        inc = cnt + 1'b1;
        if (sample == level) begin
            return {level, {DB_W{1'b0}}};
        end else if (cnt == DB_LAST) begin
            return {sample, {DB_W{1'b0}}};
        end else begin
            return {level, inc};
        end
    endfunction

    always_comb begin
        step_meta_d = btn_step;
        step_sync_d = step_meta_q;
        run_meta_d  = sw_run;
        run_sync_d  = run_meta_q;
        {step_db_d, step_cnt_d} = debounce_next(step_sync_q, step_db_q, step_cnt_q);
        {run_db_d,  run_cnt_d}  = debounce_next(run_sync_q,  run_db_q,  run_cnt_q);
        // Only the press (rising edge) of the debounced button is a step.
        step_prev_d  = step_db_q;
        step_pulse_d = step_db_q & ~step_prev_q;
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            step_meta_q  <= 1'b0;
            step_sync_q  <= 1'b0;
            run_meta_q   <= 1'b0;
            run_sync_q   <= 1'b0;
            step_db_q    <= 1'b0;
            step_cnt_q   <= '0;
            run_db_q     <= 1'b0;
            run_cnt_q    <= '0;
            step_prev_q  <= 1'b0;
            step_pulse_q <= 1'b0;
        end else begin
            step_meta_q  <= step_meta_d;
            step_sync_q  <= step_sync_d;
            run_meta_q   <= run_meta_d;
            run_sync_q   <= run_sync_d;
            step_db_q    <= step_db_d;
            step_cnt_q   <= step_cnt_d;
            run_db_q     <= run_db_d;
            run_cnt_q    <= run_cnt_d;
            step_prev_q  <= step_prev_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    // Halt is judged against the registered enable actually seen by the core,
    // and takes priority over any run-switch change in the same cycle.
    assign halt_hit = cpu_ce_q & halt_req;

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        phase_d       = phase_q;
        cpu_rst_n_d   = cpu_rst_n_q;
        cpu_ce_d      = 1'b0;
        cycle_count_d = cycle_count_q + {31'b0, cpu_ce_q};

        case (state_q)
            ST_RESET_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    cpu_rst_n_d = 1'b1;
                    phase_d     = '0;
                    state_d     = run_db_q ? ST_RUN : ST_PAUSE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (halt_hit) begin
                    state_d = ST_HALTED;
                end else if (run_db_q) begin
                    state_d = ST_RUN;
                    phase_d = '0;
                end else begin
                    cpu_ce_d = step_pulse_q;
                end
            end
            ST_RUN: begin
                if (halt_hit) begin
                    state_d = ST_HALTED;
                end else if (!run_db_q) begin
                    state_d = ST_PAUSE;
                end else begin
                    cpu_ce_d = (phase_q == PH_LAST);
                    phase_d  = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RESET_HOLD;
            end
        endcase

        // Status flags are registered from the next state so they move
        // together with the state register.
        running_d = (state_d == ST_RUN);
        halted_d  = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RESET_HOLD;
            hold_cnt_q    <= '0;
            phase_q       <= '0;
            cpu_rst_n_q   <= 1'b0;
            cpu_ce_q      <= 1'b0;
            halted_q      <= 1'b0;
            running_q     <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            phase_q       <= phase_d;
            cpu_rst_n_q   <= cpu_rst_n_d;
            cpu_ce_q      <= cpu_ce_d;
            halted_q      <= halted_d;
            running_q     <= running_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign cpu_rst_n   = cpu_rst_n_q;
    assign cpu_ce      = cpu_ce_q;
    assign halted      = halted_q;
    assign running     = running_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_step_controller
//
// Directed and randomized bench for cpu_step_controller with DEBOUNCE_CYCLES=4,
// RUN_DIV=2, RST_HOLD=4 (main instance) plus a RUN_DIV=1 instance used for the
// halt-with-continuous-enable case. Expected pulse counts, latencies and the
// cycle counter value are derived from the press/run events the bench applies.
// -----------------------------------------------------------------------------
module tb_cpu_step_controller;

    localparam int DB  = 4;
    localparam int DIV = 2;
    localparam int HLD = 4;

    logic        clk_100MHz;
    logic        rst_n;
    logic        btn_step;
    logic        sw_run;
    logic        halt_req;
    logic        halt_req1;
    logic        cpu_rst_n, cpu_ce, halted, running;
    logic [31:0] cycle_count;
    logic        cpu_rst_n1, cpu_ce1, halted1, running1;
    logic [31:0] cycle_count1;

    cpu_step_controller #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(DIV), .RST_HOLD(HLD)) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .btn_step   (btn_step),
        .sw_run     (sw_run),
        .halt_req   (halt_req),
        .cpu_rst_n  (cpu_rst_n),
        .cpu_ce     (cpu_ce),
        .halted     (halted),
        .running    (running),
        .cycle_count(cycle_count)
    );

    cpu_step_controller #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(1), .RST_HOLD(HLD)) dut1 (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .btn_step   (btn_step),
        .sw_run     (sw_run),
        .halt_req   (halt_req1),
        .cpu_rst_n  (cpu_rst_n1),
        .cpu_ce     (cpu_ce1),
        .halted     (halted1),
        .running    (running1),
        .cycle_count(cycle_count1)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          ce_cnt   = 0;
    int          ce1_cnt  = 0;
    int          ce_wide  = 0;
    int          ce_at    = 0;
    logic        prev_ce  = 1'b0;
    logic [31:0] mdl_cnt  = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and update the observation model:
    // the counter is expected to include every pulse seen on earlier edges.
    task automatic tick();
        @(negedge clk_100MHz);
        cyc++;
        mdl_cnt = mdl_cnt + {31'b0, prev_ce};
        if (cpu_ce === 1'b1) begin
            ce_cnt++;
            ce_at = cyc;
            if (prev_ce) ce_wide++;
        end
        if (cpu_ce1 === 1'b1) ce1_cnt++;
        prev_ce = (cpu_ce === 1'b1);
    endtask

    // Hold the button for 'hold' cycles then release for 'gap' cycles.
    task automatic press(input int hold, input int gap, output int got, output int lat);
        int c0;
        int t0;
        c0 = ce_cnt;
        t0 = cyc;
        btn_step = 1'b1;
        repeat (hold) tick();
        btn_step = 1'b0;
        repeat (gap) tick();
        got = ce_cnt - c0;
        lat = ce_at - t0;
    endtask

    initial begin
        int got, lat, c0, c1, n_clean, first_ce, t_run;

        rst_n     = 1'b1;
        btn_step  = 1'b0;
        sw_run    = 1'b0;
        halt_req  = 1'b0;
        halt_req1 = 1'b0;

        // Asynchronous reset before any clock edge
        #3 rst_n = 1'b0;
        #1;
        check("rst_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
        check("rst_cpu_ce",    {31'b0, cpu_ce},    32'd0);
        check("rst_halted",    {31'b0, halted},    32'd0);
        check("rst_running",   {31'b0, running},   32'd0);
        check("rst_count",     cycle_count,        32'd0);

        repeat (3) tick();
        rst_n = 1'b1;
        repeat (HLD - 1) tick();
        check("hold_still_low", {31'b0, cpu_rst_n}, 32'd0);
        tick();
        check("hold_released", {31'b0, cpu_rst_n}, 32'd1);
        check("pause_not_running", {31'b0, running}, 32'd0);
        check("pause_not_halted",  {31'b0, halted},  32'd0);
        c0 = ce_cnt;
        repeat (100) tick();
        check("pause_no_ce", ce_cnt - c0, 32'd0);
        check("pause_count_zero", cycle_count, 32'd0);

        // Three clean presses
        for (int i = 0; i < 3; i++) begin
            press(20, 20, got, lat);
            check("clean_press_pulses", got, 32'd1);
            check("clean_press_latency_ok", {31'b0, (lat >= DB + 3 && lat <= DB + 5)}, 32'd1);
        end
        check("clean_count", cycle_count, 32'd3);
        check("clean_single_cycle", ce_wide, 32'd0);

        // Randomized mix of clean presses and sub-debounce glitches
        n_clean = 0;
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                press($urandom_range(DB + 2, 15), $urandom_range(DB + 4, 15), got, lat);
                n_clean++;
                check("rand_press_pulses", got, 32'd1);
                check("rand_press_latency_ok", {31'b0, (lat >= DB + 3 && lat <= DB + 5)}, 32'd1);
            end else begin
                press($urandom_range(1, DB - 1), 10, got, lat);
                check("rand_glitch_pulses", got, 32'd0);
            end
        end
        check("rand_count", cycle_count, 32'(3 + n_clean));

        // Bouncy press: 2-cycle toggles, then a solid hold
        c0 = ce_cnt;
        for (int i = 0; i < 12; i++) begin
            btn_step = ((i / 2) % 2) == 0;
            tick();
        end
        btn_step = 1'b1;
        repeat (20) tick();
        btn_step = 1'b0;
        repeat (20) tick();
        check("bouncy_pulses", ce_cnt - c0, 32'd1);
        press(3, 20, got, lat);
        check("glitch3_pulses", got, 32'd0);
        check("step_count_model", cycle_count, mdl_cnt);
        check("step_single_cycle", ce_wide, 32'd0);

        // Free run
        sw_run = 1'b1;
        for (int n = 0; n < 30 && running !== 1'b1; n++) tick();
        check("run_entered", {31'b0, running}, 32'd1);
        t_run    = cyc;
        first_ce = -1;
        c0       = ce_cnt;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (first_ce < 0 && cpu_ce === 1'b1) first_ce = cyc;
        end
        check("run_first_ce_delay", first_ce - t_run, 32'(DIV));
        check("run_pulses_100", ce_cnt - c0, 32'd50);
        check("run_no_wide", ce_wide, 32'd0);
        check("run_count_model", cycle_count, mdl_cnt);

        sw_run = 1'b0;
        repeat (DB + 8) tick();
        check("run_dropped", {31'b0, running}, 32'd0);
        c0 = ce_cnt;
        repeat (30) tick();
        check("run_dropped_no_ce", ce_cnt - c0, 32'd0);
        check("run_dropped_count", cycle_count, mdl_cnt);

        // Halt from RUN (both RUN_DIV=2 and RUN_DIV=1)
        sw_run = 1'b1;
        for (int n = 0; n < 30 && running !== 1'b1; n++) tick();
        check("halt_run_entered", {31'b0, running}, 32'd1);
        for (int n = 0; n < 5 && cpu_ce !== 1'b1; n++) tick();
        check("halt_on_ce", {31'b0, cpu_ce}, 32'd1);
        check("halt1_on_ce", {31'b0, cpu_ce1}, 32'd1);
        halt_req  = 1'b1;
        halt_req1 = 1'b1;
        tick();
        halt_req  = 1'b0;
        halt_req1 = 1'b0;
        check("halted_set",   {31'b0, halted},  32'd1);
        check("halted_no_ce", {31'b0, cpu_ce},  32'd0);
        check("halted_not_running", {31'b0, running}, 32'd0);
        check("halted1_set",   {31'b0, halted1}, 32'd1);
        check("halted1_no_ce", {31'b0, cpu_ce1}, 32'd0);
        c0 = ce_cnt;
        c1 = ce1_cnt;
        sw_run = 1'b0;
        press(10, 10, got, lat);
        sw_run = 1'b1;
        press(10, 10, got, lat);
        repeat (20) tick();
        check("halted_stays_no_ce", ce_cnt - c0, 32'd0);
        check("halted1_stays_no_ce", ce1_cnt - c1, 32'd0);
        check("halted_stays", {31'b0, halted}, 32'd1);
        check("halted_count", cycle_count, mdl_cnt);

        // Reset out of HALTED, then reset again mid-RUN at count 0x37
        rst_n   = 1'b0;
        prev_ce = 1'b0;
        mdl_cnt = 32'd0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int n = 0; n < 40 && running !== 1'b1; n++) tick();
        check("rerun_entered", {31'b0, running}, 32'd1);
        for (int n = 0; n < 300 && cycle_count !== 32'h37; n++) tick();
        check("rerun_count_37", cycle_count, 32'h37);
        #2 rst_n = 1'b0;
        #1;
        prev_ce = 1'b0;
        mdl_cnt = 32'd0;
        check("midrst_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
        check("midrst_cpu_ce",    {31'b0, cpu_ce},    32'd0);
        check("midrst_halted",    {31'b0, halted},    32'd0);
        check("midrst_running",   {31'b0, running},   32'd0);
        check("midrst_count",     cycle_count,        32'd0);

        // Counter wrap: preload all-ones while paused, then one step
        sw_run = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int n = 0; n < 10 && cpu_rst_n !== 1'b1; n++) tick();
        check("wrap_rst_released", {31'b0, cpu_rst_n}, 32'd1);
        repeat (5) tick();
        check("wrap_paused", {31'b0, running}, 32'd0);
        force dut.cycle_count_q = 32'hFFFF_FFFF;
        mdl_cnt = 32'hFFFF_FFFF;
        repeat (2) tick();
        release dut.cycle_count_q;
        tick();
        check("wrap_preloaded", cycle_count, 32'hFFFF_FFFF);
        press(20, 20, got, lat);
        check("wrap_step_pulse", got, 32'd1);
        check("wrap_count_zero", cycle_count, 32'd0);
        check("wrap_count_model", cycle_count, mdl_cnt);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
